// File: rtl/ip_frame_scheduler_if.sv
// Frame-buffer, datapath and control signals of the frame scheduler.
// The master modport is the scheduler's side; slave is the surrounding system.
interface ip_frame_scheduler_if #(
  parameter int ADDR_W = 19
);
  logic              start;
  logic [9:0]        mode_in;
  logic              busy;
  logic              done;
  logic [9:0]        mode_out;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic [23:0]       ip_pixel_out;
  logic [23:0]       ip_pixel_in;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;

  modport master (
    input  start, mode_in, rd_data, ip_pixel_in, wr_ready,
    output busy, done, mode_out, rd_en, rd_addr, ip_pixel_out, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, mode_in, rd_data, ip_pixel_in, wr_ready,
    input  busy, done, mode_out, rd_en, rd_addr, ip_pixel_out, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/ip_frame_scheduler.sv
// Walks one frame through the image datapath in groups of up to 8 pixels:
// read a group, stream it through the datapath, buffer the results, write them back.
module ip_frame_scheduler #(
  parameter int H_PIXELS   = 640,
  parameter int V_PIXELS   = 480,
  parameter int ADDR_W     = 19,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  ip_frame_scheduler_if.master bus
);

  localparam int TOTAL = H_PIXELS * V_PIXELS;
  localparam int PIPE  = RD_LATENCY + 2;
  localparam logic [ADDR_W:0] TOTAL_W = (ADDR_W + 1)'(TOTAL);
  localparam logic [ADDR_W:0] GROUP_W = (ADDR_W + 1)'(8);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] base;
  logic [2:0]        rd_idx, wr_idx;
  logic [9:0]        mode_reg;
  logic [23:0]       pixel_reg;
  logic [PIPE-1:0]   pipe_vld;
  logic [2:0]        pipe_idx [PIPE];
  logic [23:0]       grp_buf [8];

  logic [ADDR_W:0]   remaining;
  logic [3:0]        grp_n;
  logic              last_rd, last_wr, cap_last, wr_fire, more;

  // The final group of a frame may be shorter than 8 pixels.
  always_comb begin
    remaining = TOTAL_W - {1'b0, base};
    grp_n     = (remaining >= GROUP_W) ? 4'd8 : remaining[3:0];
    last_rd   = ({1'b0, rd_idx} == grp_n - 4'd1);
    last_wr   = ({1'b0, wr_idx} == grp_n - 4'd1);
    cap_last  = pipe_vld[PIPE-1] && ({1'b0, pipe_idx[PIPE-1]} == grp_n - 4'd1);
    wr_fire   = (state == WRITE) && bus.wr_ready;
    more      = remaining > (ADDR_W + 1)'(grp_n);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = READ;
      READ:    if (last_rd) next_state = WAIT;
      WAIT:    if (cap_last) next_state = WRITE;
      WRITE:   if (wr_fire && last_wr) next_state = more ? READ : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base      <= '0;
      rd_idx    <= '0;
      wr_idx    <= '0;
      mode_reg  <= '0;
      pixel_reg <= '0;
      pipe_vld  <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        mode_reg <= bus.mode_in;
        base     <= '0;
        rd_idx   <= '0;
        wr_idx   <= '0;
      end
      if (state == READ) rd_idx <= last_rd ? 3'd0 : rd_idx + 3'd1;
      if (wr_fire) begin
        wr_idx <= last_wr ? 3'd0 : wr_idx + 3'd1;
        if (last_wr && more) base <= base + ADDR_W'(grp_n);
      end
      pipe_vld <= {pipe_vld[PIPE-2:0], state == READ};
      // Stage RD_LATENCY-1 marks the cycle the memory presents the requested pixel.
      if (pipe_vld[RD_LATENCY-1]) pixel_reg <= bus.rd_data;
    end
  end

  always_ff @(posedge clock) begin
    pipe_idx[0] <= rd_idx;
    for (int i = 1; i < PIPE; i++) pipe_idx[i] <= pipe_idx[i-1];
    if (pipe_vld[PIPE-1]) grp_buf[pipe_idx[PIPE-1]] <= bus.ip_pixel_in;
  end

  always_comb begin
    bus.busy         = (state != IDLE);
    bus.done         = (state == DONE);
    bus.mode_out     = mode_reg;
    bus.ip_pixel_out = pixel_reg;
    bus.rd_en        = 1'b0;
    bus.rd_addr      = '0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    if (state == READ) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = base + ADDR_W'(rd_idx);
    end
    if (state == WRITE) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = base + ADDR_W'(wr_idx);
      bus.wr_data = grp_buf[wr_idx];
    end
  end

endmodule

// File: tb/tb_ip_frame_scheduler.sv
// Directed bench: a 4x4 frame scheduler (full groups) and a 5x3 one (partial last group)
// against a memory holding memory[a]=a and a pass-through one-cycle datapath.
module tb_ip_frame_scheduler;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ip_frame_scheduler_if bus_a ();
  ip_frame_scheduler_if bus_b ();

  ip_frame_scheduler #(.H_PIXELS(4), .V_PIXELS(4), .ADDR_W(19), .RD_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a)
  );
  ip_frame_scheduler #(.H_PIXELS(5), .V_PIXELS(3), .ADDR_W(19), .RD_LATENCY(1)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b)
  );

  typedef struct {
    int cyc;
    int wr_ready;
    int rd_en;
    int rd_addr;
    int wr_en;
    int wr_addr;
    int wr_data;
    int busy;
    int done;
  } vec_t;

  vec_t vecs [14];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   c       = 0;
  int   cyc     = 0;

  int   rd_log_a[$], wr_log_a[$], wd_log_a[$];
  int   rd_log_b[$], wr_log_b[$], wd_log_b[$];
  int   done_cnt_a, done_cyc_a, last_wr_a, overlap_a;
  int   done_cnt_b, done_cyc_b, last_wr_b, overlap_b;

  // Memory returns its own address one cycle after a read; anything else is garbage.
  always @(posedge clock) begin
    bus_a.rd_data     <= bus_a.rd_en ? 24'(bus_a.rd_addr) : 24'hBADBAD;
    bus_b.rd_data     <= bus_b.rd_en ? 24'(bus_b.rd_addr) : 24'hBADBAD;
    bus_a.ip_pixel_in <= bus_a.ip_pixel_out;
    bus_b.ip_pixel_in <= bus_b.ip_pixel_out;
  end

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (bus_a.rd_en) rd_log_a.push_back(int'(bus_a.rd_addr));
      if (bus_a.wr_en && bus_a.wr_ready) begin
        wr_log_a.push_back(int'(bus_a.wr_addr));
        wd_log_a.push_back(int'(bus_a.wr_data));
        last_wr_a = cyc;
      end
      if (bus_a.done) begin done_cnt_a++; done_cyc_a = cyc; end
      if (bus_a.rd_en && bus_a.wr_en) overlap_a++;
      if (bus_b.rd_en) rd_log_b.push_back(int'(bus_b.rd_addr));
      if (bus_b.wr_en && bus_b.wr_ready) begin
        wr_log_b.push_back(int'(bus_b.wr_addr));
        wd_log_b.push_back(int'(bus_b.wr_data));
        last_wr_b = cyc;
      end
      if (bus_b.done) begin done_cnt_b++; done_cyc_b = cyc; end
      if (bus_b.rd_en && bus_b.wr_en) overlap_b++;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Checks a log holds exactly 0..n-1 in order.
  task automatic check_seq(input string name, input int q[$], input int n);
    int bad = -1;
    check_output({name, " count"}, q.size(), n);
    foreach (q[i]) if (bad < 0 && q[i] != i) bad = i;
    check_output({name, " first out-of-order index"}, bad, -1);
  endtask

  task automatic clear_logs();
    rd_log_a.delete(); wr_log_a.delete(); wd_log_a.delete();
    rd_log_b.delete(); wr_log_b.delete(); wd_log_b.delete();
    done_cnt_a = 0; done_cyc_a = 0; last_wr_a = 0; overlap_a = 0;
    done_cnt_b = 0; done_cyc_b = 0; last_wr_b = 0; overlap_b = 0;
  endtask

  task automatic step_to(input int target);
    while (c < target) begin
      @(negedge clock);
      c++;
    end
  endtask

  // Pulses start for one cycle; on return the bench sits in cycle 0 of the frame.
  task automatic apply_stimulus(input logic [9:0] mode, input logic use_b);
    @(negedge clock);
    bus_a.start   = 1'b1;
    bus_a.mode_in = mode;
    bus_b.start   = use_b;
    @(negedge clock);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    c = 0;
  endtask

  task automatic wait_done(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus_a.done) seen = 1'b1;
      else begin
        @(negedge clock);
        c++;
      end
    end
    check_output({name, " done within budget"}, int'(seen), 1);
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, " busy"}, int'(bus_a.busy), 0);
    check_output({name, " done"}, int'(bus_a.done), 0);
    check_output({name, " mode_out"}, int'(bus_a.mode_out), 0);
    check_output({name, " rd_en"}, int'(bus_a.rd_en), 0);
    check_output({name, " rd_addr"}, int'(bus_a.rd_addr), 0);
    check_output({name, " wr_en"}, int'(bus_a.wr_en), 0);
    check_output({name, " wr_addr"}, int'(bus_a.wr_addr), 0);
    check_output({name, " wr_data"}, int'(bus_a.wr_data), 0);
    check_output({name, " ip_pixel_out"}, int'(bus_a.ip_pixel_out), 0);
  endtask

  initial begin
    // cyc, wr_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
    vecs[0]  = '{0,  1, 1, 0,  0, 0,  0,  1, 0};
    vecs[1]  = '{7,  1, 1, 7,  0, 0,  0,  1, 0};
    vecs[2]  = '{8,  1, 0, 0,  0, 0,  0,  1, 0};
    vecs[3]  = '{10, 1, 0, 0,  0, 0,  0,  1, 0};
    vecs[4]  = '{11, 1, 0, 0,  1, 0,  0,  1, 0};
    vecs[5]  = '{14, 1, 0, 0,  1, 3,  3,  1, 0};
    vecs[6]  = '{18, 1, 0, 0,  1, 7,  7,  1, 0};
    vecs[7]  = '{19, 1, 1, 8,  0, 0,  0,  1, 0};
    vecs[8]  = '{26, 1, 1, 15, 0, 0,  0,  1, 0};
    vecs[9]  = '{29, 1, 0, 0,  0, 0,  0,  1, 0};
    vecs[10] = '{30, 1, 0, 0,  1, 8,  8,  1, 0};
    vecs[11] = '{37, 1, 0, 0,  1, 15, 15, 1, 0};
    vecs[12] = '{38, 1, 0, 0,  0, 0,  0,  1, 1};
    vecs[13] = '{39, 1, 0, 0,  0, 0,  0,  0, 0};

    reset = 1'b1;
    bus_a.start = 1'b0; bus_a.mode_in = '0; bus_a.wr_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.mode_in = '0; bus_b.wr_ready = 1'b1;
    clear_logs();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset");

    $display("[TB] full 4x4 frame and partial-group 5x3 frame");
    clear_logs();
    apply_stimulus(10'd0, 1'b1);
    foreach (vecs[i]) begin
      step_to(vecs[i].cyc);
      check_output($sformatf("vec%0d rd_en", i), int'(bus_a.rd_en), vecs[i].rd_en);
      check_output($sformatf("vec%0d rd_addr", i), int'(bus_a.rd_addr), vecs[i].rd_addr);
      check_output($sformatf("vec%0d wr_en", i), int'(bus_a.wr_en), vecs[i].wr_en);
      check_output($sformatf("vec%0d wr_addr", i), int'(bus_a.wr_addr), vecs[i].wr_addr);
      check_output($sformatf("vec%0d wr_data", i), int'(bus_a.wr_data), vecs[i].wr_data);
      check_output($sformatf("vec%0d busy", i), int'(bus_a.busy), vecs[i].busy);
      check_output($sformatf("vec%0d done", i), int'(bus_a.done), vecs[i].done);
      bus_a.wr_ready = 1'(vecs[i].wr_ready);
    end
    check_seq("A reads", rd_log_a, 16);
    check_seq("A write addrs", wr_log_a, 16);
    check_seq("A write data", wd_log_a, 16);
    check_output("A done pulses", done_cnt_a, 1);
    check_output("A done after last write", done_cyc_a - last_wr_a, 1);
    check_output("A rd/wr overlap", overlap_a, 0);
    check_seq("B reads", rd_log_b, 15);
    check_seq("B write addrs", wr_log_b, 15);
    check_seq("B write data", wd_log_b, 15);
    check_output("B done pulses", done_cnt_b, 1);
    check_output("B done after last write", done_cyc_b - last_wr_b, 1);
    check_output("B rd/wr overlap", overlap_b, 0);

    $display("[TB] write backpressure, mode latch, ignored mid-frame start");
    clear_logs();
    apply_stimulus(10'b0000000100, 1'b0);
    bus_a.mode_in = '0;
    step_to(5);
    bus_a.start = 1'b1;
    step_to(6);
    bus_a.start = 1'b0;
    step_to(13);
    bus_a.wr_ready = 1'b0;
    for (int k = 13; k <= 16; k++) begin
      step_to(k);
      check_output($sformatf("stall c%0d wr_en", k), int'(bus_a.wr_en), 1);
      check_output($sformatf("stall c%0d wr_addr", k), int'(bus_a.wr_addr), 2);
      check_output($sformatf("stall c%0d wr_data", k), int'(bus_a.wr_data), 2);
      if (k == 13) bus_a.wr_ready = 1'b0;
      if (k == 16) bus_a.wr_ready = 1'b1;
    end
    step_to(17);
    check_output("after stall wr_addr", int'(bus_a.wr_addr), 3);
    check_output("mid-frame mode_out", int'(bus_a.mode_out), 4);
    wait_done("stall frame");
    check_output("done-cycle mode_out", int'(bus_a.mode_out), 4);
    check_seq("stall write addrs", wr_log_a, 16);
    check_seq("stall write data", wd_log_a, 16);
    repeat (6) @(negedge clock);
    check_output("no second frame busy", int'(bus_a.busy), 0);
    check_output("no second frame reads", rd_log_a.size(), 16);
    check_output("no second frame done", done_cnt_a, 1);
    check_output("mode_out held after done", int'(bus_a.mode_out), 4);

    $display("[TB] reset during write");
    clear_logs();
    apply_stimulus(10'h2A, 1'b0);
    step_to(12);
    check_output("pre-reset wr_en", int'(bus_a.wr_en), 1);
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("mid-write reset");
    reset = 1'b0;
    clear_logs();
    repeat (40) @(negedge clock);
    check_output("post-reset writes", wr_log_a.size(), 0);
    check_output("post-reset reads", rd_log_a.size(), 0);
    check_output("post-reset done", done_cnt_a, 0);
    apply_stimulus(10'd0, 1'b0);
    check_output("restart rd_en", int'(bus_a.rd_en), 1);
    check_output("restart rd_addr", int'(bus_a.rd_addr), 0);
    wait_done("restart frame");
    check_seq("restart reads", rd_log_a, 16);

    $display("[TB] start on the done cycle");
    bus_a.start = 1'b1;
    @(negedge clock);
    check_output("start on done ignored busy", int'(bus_a.busy), 0);
    check_output("start on done ignored rd_en", int'(bus_a.rd_en), 0);
    @(negedge clock);
    bus_a.start = 1'b0;
    c = 0;
    check_output("idle start rd_en", int'(bus_a.rd_en), 1);
    check_output("idle start rd_addr", int'(bus_a.rd_addr), 0);
    check_output("idle start busy", int'(bus_a.busy), 1);
    wait_done("idle start frame");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ip_frame_scheduler.md
Name: ip_frame_scheduler

Overview:
- Sequences one full frame of pixels through the IMAGE_PROCESSING datapath in groups of 8, matching that block's 3-bit relative pixel address.
- Per group: reads pixels from frame memory, streams them into the datapath, captures the results into an 8-entry buffer, then writes them back in place with write backpressure.
- Latches the processing mode once per frame and drives the datapath decision switches.
- Sits between the frame buffer, the IMAGE_PROCESSING instance and the top-level control.

Parameters:
- H_PIXELS, 640, pixels per line
- V_PIXELS, 480, lines per frame
- ADDR_W, 19, memory address width; must hold H_PIXELS*V_PIXELS-1
- RD_LATENCY, 1, cycles from rd_en to valid rd_data (range 1..4)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  frame request; accepted only in IDLE
- mode_in  in  10  processing mode, sampled when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame completion
- mode_out  out  10  drives the datapath decision switches
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  read address
- rd_data  in  24  {R[23:16],G[15:8],B[7:0]}, valid RD_LATENCY cycles after rd_en
- ip_pixel_out  out  24  registered pixel to the datapath R/G/B inputs
- ip_pixel_in  in  24  datapath R/G/B outputs (datapath has 1-cycle registered latency)
- wr_en  out  1  write request
- wr_ready  in  1  memory accepts the write this cycle
- wr_addr  out  ADDR_W  write address
- wr_data  out  24  write data

Behaviour:
- Reset value of every output is 0; the FSM goes to IDLE and the group buffer contents become don't-care.
- Reset mid-frame aborts immediately: no further rd_en or wr_en, no done pulse. Memory may hold a partially processed frame.
- TOTAL = H_PIXELS*V_PIXELS. Groups start at base = 0, 8, 16, ...; group length n = min(8, TOTAL-base). The final group may be partial. Addresses ≥ TOTAL are never accessed.
- IDLE: start=1 → mode_out<=mode_in, base<=0, go to READ next cycle. mode_out then holds constant until the next accepted start. It is not cleared at done.
- READ: n consecutive cycles with rd_en=1, rd_addr=base+k for k=0..n-1, then go to WAIT.
- Data path: rd_data is registered into ip_pixel_out. The datapath result for pixel k arrives on ip_pixel_in RD_LATENCY+2 cycles after its rd_en and is captured into buf[k]. Track capture with a valid/index shift pipeline, not a free-running counter.
- WAIT: hold until buf[n-1] has been captured, then go to WRITE the next cycle.
- WRITE: wr_en=1, wr_addr=base+j, wr_data=buf[j].
  - j advances only on wr_en && wr_ready.
  - While wr_ready=0, wr_addr and wr_data stay stable.
  - After write n-1 is accepted: if base+n < TOTAL, set base<=base+n and go to READ; otherwise go to DONE.
- DONE: exactly one cycle with done=1 and busy=1, then IDLE.
- start outside IDLE (including the DONE cycle) is ignored and not queued. A change on mode_in mid-frame has no effect.
- rd_en and wr_en are never high in the same cycle. Each address is read once and written once per frame.
- Group timing with wr_ready=1 and n=8: first wr_en occurs 8+RD_LATENCY+2 cycles after the first rd_en. Group period is 2n+RD_LATENCY+2 cycles.

Test Plan:
- H=4, V=4, RD_LATENCY=1, mode_in=0, memory[a]=a, wr_ready=1, start pulse → reads 0..7 then 8..15. First wr_en 11 cycles after first rd_en. Writes carry values equal to the addresses. done pulses once after write 15; busy falls the next cycle.
- H=5, V=3 (TOTAL=15) → second group reads/writes addresses 8..14 only (7 each). Address 15 never appears. done follows write 14.
- wr_ready held low 3 cycles during write j=2 → wr_addr=base+2 and wr_data stable for those cycles. Remaining writes resume in order with no skips or duplicates.
- start with mode_in=10'b0000000100, then mode_in=0 and start=1 mid-frame → mode_out stays 10'b0000000100 for the whole frame; no second frame begins.
- Reset asserted during a WRITE → next cycle all outputs are 0 and no further wr_en appears. A later start reads from address 0 again.
- start asserted on the DONE cycle → ignored. start on the following IDLE cycle → accepted, rd_en at address 0 on the next cycle.
